// File: rtl/fetch_stage.sv
// fetch_stage: instruction-fetch stage of the 16-bit pipelined CPU.
// Owns the PC, issues single-outstanding reads to instruction memory and
// drives the IF/ID pipeline register. It honours a decode-side stall and a
// later-stage redirect, which flushes the stage and has priority over stall.
// Optional build macro FETCH_PERF_CNT_EN adds the perf_fetched/perf_stall
// counters and their output ports.
module fetch_stage #(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter logic [15:0] NOP_INST = 16'h0000
) (
    input  logic        clock,
    input  logic        reset,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic        imem_valid,
    input  logic [15:0] imem_rdata,
    input  logic        stall,
    input  logic        redirect,
    input  logic [15:0] redirect_pc,
    output logic [15:0] IF_ID_Inst,
    output logic [15:0] IF_ID_PC,
    output logic        IF_ID_valid,
    output logic [15:0] pc_out
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [15:0] perf_fetched,
    output logic [15:0] perf_stall
`endif
);

    localparam int unsigned XLEN = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        BUF   = 2'd2,
        DRAIN = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;

    logic [XLEN-1:0]   r_fetch_pc;
    logic [XLEN-1:0]   r_redir_pc;
    logic [XLEN-1:0]   r_buf_inst;
    logic [XLEN-1:0]   r_buf_pc;
    logic [XLEN-1:0]   r_inst;
    logic [XLEN-1:0]   r_pc;
    logic              r_valid;

    logic [XLEN-1:0]   w_fetch_pc_nxt;
    logic [XLEN-1:0]   w_redir_pc_nxt;
    logic [XLEN-1:0]   w_buf_inst_nxt;
    logic [XLEN-1:0]   w_buf_pc_nxt;
    logic [XLEN-1:0]   w_inst_nxt;
    logic [XLEN-1:0]   w_pc_nxt;
    logic              w_valid_nxt;
    logic              w_load;
    logic              w_accept;
    logic [XLEN-1:0]   w_pc_inc;

    // IF/ID can take a new instruction when decode is not stalled or it is empty
    assign w_accept = ~stall | ~r_valid;
    assign w_pc_inc = r_fetch_pc + XLEN'(1);

    // State register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and next-value logic for the whole stage
    always_comb begin
        w_state_nxt    = r_state;
        w_fetch_pc_nxt = r_fetch_pc;
        w_redir_pc_nxt = r_redir_pc;
        w_buf_inst_nxt = r_buf_inst;
        w_buf_pc_nxt   = r_buf_pc;
        w_inst_nxt     = r_inst;
        w_pc_nxt       = r_pc;
        w_valid_nxt    = r_valid;
        w_load         = 1'b0;

        // A consumed slot with nothing new behind it becomes a bubble
        if (w_accept) begin
            w_valid_nxt = 1'b0;
        end

        case (r_state)
            IDLE: begin
                w_state_nxt = REQ;
                if (redirect) begin
                    w_fetch_pc_nxt = redirect_pc;
                end
            end

            REQ: begin
                if (redirect) begin
                    if (imem_valid) begin
                        w_fetch_pc_nxt = redirect_pc;
                    end else begin
                        // Request in flight: keep its address, retarget after it returns
                        w_redir_pc_nxt = redirect_pc;
                        w_state_nxt    = DRAIN;
                    end
                end else if (imem_valid) begin
                    w_fetch_pc_nxt = w_pc_inc;
                    if (w_accept) begin
                        w_inst_nxt  = imem_rdata;
                        w_pc_nxt    = r_fetch_pc;
                        w_valid_nxt = 1'b1;
                        w_load      = 1'b1;
                    end else begin
                        w_buf_inst_nxt = imem_rdata;
                        w_buf_pc_nxt   = r_fetch_pc;
                        w_state_nxt    = BUF;
                    end
                end
            end

            BUF: begin
                if (redirect) begin
                    w_fetch_pc_nxt = redirect_pc;
                    w_state_nxt    = REQ;
                end else if (!stall) begin
                    w_inst_nxt  = r_buf_inst;
                    w_pc_nxt    = r_buf_pc;
                    w_valid_nxt = 1'b1;
                    w_load      = 1'b1;
                    w_state_nxt = REQ;
                end
            end

            DRAIN: begin
                if (redirect) begin
                    if (imem_valid) begin
                        w_fetch_pc_nxt = redirect_pc;
                        w_state_nxt    = REQ;
                    end else begin
                        w_redir_pc_nxt = redirect_pc;
                    end
                end else if (imem_valid) begin
                    w_fetch_pc_nxt = r_redir_pc;
                    w_state_nxt    = REQ;
                end
            end

            default: begin
                w_state_nxt = IDLE;
            end
        endcase

        // Flush wins over everything, including stall
        if (redirect) begin
            w_valid_nxt = 1'b0;
            w_inst_nxt  = NOP_INST;
            w_load      = 1'b0;
        end
    end

    // Datapath registers: PC, pending redirect target, skid buffer, IF/ID
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_fetch_pc <= RESET_PC;
            r_redir_pc <= '0;
            r_buf_inst <= '0;
            r_buf_pc   <= '0;
            r_inst     <= NOP_INST;
            r_pc       <= '0;
            r_valid    <= 1'b0;
        end else begin
            r_fetch_pc <= w_fetch_pc_nxt;
            r_redir_pc <= w_redir_pc_nxt;
            r_buf_inst <= w_buf_inst_nxt;
            r_buf_pc   <= w_buf_pc_nxt;
            r_inst     <= w_inst_nxt;
            r_pc       <= w_pc_nxt;
            r_valid    <= w_valid_nxt;
        end
    end

    assign imem_req    = (r_state == REQ) || (r_state == DRAIN);
    assign imem_addr   = r_fetch_pc;
    assign pc_out      = r_fetch_pc;
    assign IF_ID_Inst  = r_inst;
    assign IF_ID_PC    = r_pc;
    assign IF_ID_valid = r_valid;

`ifdef FETCH_PERF_CNT_EN
    logic [XLEN-1:0] r_perf_fetched;
    logic [XLEN-1:0] r_perf_stall;

    // Count valid IF/ID loads and cycles a real instruction sits stalled
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_perf_fetched <= '0;
            r_perf_stall   <= '0;
        end else begin
            if (w_load) begin
                r_perf_fetched <= r_perf_fetched + XLEN'(1);
            end
            if (stall && r_valid) begin
                r_perf_stall <= r_perf_stall + XLEN'(1);
            end
        end
    end

    assign perf_fetched = r_perf_fetched;
    assign perf_stall   = r_perf_stall;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed bench for fetch_stage with a latency-programmable
// instruction memory that returns addr ^ 16'hA000.
module tb_fetch_stage;

    logic        clock;
    logic        reset;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_valid;
    logic [15:0] imem_rdata;
    logic        stall;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic [15:0] IF_ID_Inst;
    logic [15:0] IF_ID_PC;
    logic        IF_ID_valid;
    logic [15:0] pc_out;
`ifdef FETCH_PERF_CNT_EN
    logic [15:0] perf_fetched;
    logic [15:0] perf_stall;
`endif

    int n_cmp;
    int n_err;
    int mem_lat;
    int mem_cnt;

    fetch_stage #(
        .RESET_PC (16'h0010),
        .NOP_INST (16'h0000)
    ) u_dut (
        .clock       (clock),
        .reset       (reset),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_valid  (imem_valid),
        .imem_rdata  (imem_rdata),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .IF_ID_Inst  (IF_ID_Inst),
        .IF_ID_PC    (IF_ID_PC),
        .IF_ID_valid (IF_ID_valid),
        .pc_out      (pc_out)
`ifdef FETCH_PERF_CNT_EN
        ,
        .perf_fetched(perf_fetched),
        .perf_stall  (perf_stall)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Memory: answers after mem_lat extra cycles of a held request
    assign imem_valid = imem_req && (mem_cnt >= mem_lat);
    assign imem_rdata = imem_addr ^ 16'hA000;

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            mem_cnt <= 0;
        end else if (!imem_req || imem_valid) begin
            mem_cnt <= 0;
        end else begin
            mem_cnt <= mem_cnt + 1;
        end
    end

    task automatic check_val(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check_ifid(input string tag, input logic v, input logic [15:0] pc, input logic [15:0] inst);
        check_val({tag, "_valid"}, 16'(IF_ID_valid), 16'(v));
        check_val({tag, "_pc"}, IF_ID_PC, pc);
        check_val({tag, "_inst"}, IF_ID_Inst, inst);
    endtask

    initial begin
        n_cmp       = 0;
        n_err       = 0;
        mem_lat     = 0;
        reset       = 1'b0;
        stall       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 16'h0000;

        // Reset state
        tick(); tick();
        check_ifid("rst", 1'b0, 16'h0000, 16'h0000);
        check_val("rst_req", 16'(imem_req), 16'h0000);
        check_val("rst_pc_out", pc_out, 16'h0010);
        reset = 1'b1;

        // Zero-wait streaming from RESET_PC
        tick(); // E1: IDLE -> REQ
        check_val("e1_valid", 16'(IF_ID_valid), 16'h0000);
        check_val("e1_req", 16'(imem_req), 16'h0001);
        check_val("e1_addr", imem_addr, 16'h0010);
        tick(); check_ifid("e2", 1'b1, 16'h0010, 16'hA010);
        tick(); check_ifid("e3", 1'b1, 16'h0011, 16'hA011);
        tick(); check_ifid("e4", 1'b1, 16'h0012, 16'hA012);
        check_val("e4_addr", imem_addr, 16'h0013);

        // Three-cycle memory: address held, bubbles keep previous contents
        mem_lat = 2;
        tick(); check_ifid("e5", 1'b0, 16'h0012, 16'hA012);
        check_val("e5_addr", imem_addr, 16'h0013);
        tick(); check_val("e6_addr", imem_addr, 16'h0013);
        check_val("e6_valid", 16'(IF_ID_valid), 16'h0000);
        tick(); check_ifid("e7", 1'b1, 16'h0013, 16'hA013);
        check_val("e7_addr", imem_addr, 16'h0014);

        // Stall 4 cycles while response 0014 arrives -> buffered
        stall = 1'b1;
        tick(); check_ifid("e8", 1'b1, 16'h0013, 16'hA013);
        tick(); tick();
        check_val("e10_req", 16'(imem_req), 16'h0000);
        check_ifid("e10", 1'b1, 16'h0013, 16'hA013);
        tick();
        check_val("e11_req", 16'(imem_req), 16'h0000);
        check_ifid("e11", 1'b1, 16'h0013, 16'hA013);
        stall = 1'b0;
        tick(); check_ifid("e12", 1'b1, 16'h0014, 16'hA014);
        check_val("e12_addr", imem_addr, 16'h0015);
        mem_lat = 0;
        tick(); check_ifid("e13", 1'b1, 16'h0015, 16'hA015);

        // Redirect with same-cycle response: go to 0005
        redirect    = 1'b1;
        redirect_pc = 16'h0005;
        tick();
        redirect = 1'b0;
        mem_lat  = 2;
        check_ifid("e14", 1'b0, 16'h0015, 16'h0000);
        check_val("e14_addr", imem_addr, 16'h0005);

        // Redirect to 0200 while request to 0005 is pending -> drain
        tick();
        redirect    = 1'b1;
        redirect_pc = 16'h0200;
        tick();
        redirect = 1'b0;
        check_val("e16_req", 16'(imem_req), 16'h0001);
        check_val("e16_addr", imem_addr, 16'h0005);
        check_val("e16_valid", 16'(IF_ID_valid), 16'h0000);
        check_val("e16_inst", IF_ID_Inst, 16'h0000);
        tick();
        check_val("e17_addr", imem_addr, 16'h0200);
        check_val("e17_req", 16'(imem_req), 16'h0001);
        check_val("e17_valid", 16'(IF_ID_valid), 16'h0000);
        mem_lat = 0;
        tick(); check_ifid("e18", 1'b1, 16'h0200, 16'hA200);

        // Redirect + stall with valid slot: flush wins, buffer dropped
        stall = 1'b1;
        tick();
        check_val("e19_req", 16'(imem_req), 16'h0000);
        check_ifid("e19", 1'b1, 16'h0200, 16'hA200);
        redirect    = 1'b1;
        redirect_pc = 16'h0300;
        tick();
        redirect = 1'b0;
        stall    = 1'b0;
        check_val("e20_valid", 16'(IF_ID_valid), 16'h0000);
        check_val("e20_inst", IF_ID_Inst, 16'h0000);
        check_val("e20_addr", imem_addr, 16'h0300);
        tick(); check_ifid("e21", 1'b1, 16'h0300, 16'hA300);

        // PC wrap at FFFF
        redirect    = 1'b1;
        redirect_pc = 16'hFFFF;
        tick();
        redirect = 1'b0;
        check_val("e22_addr", imem_addr, 16'hFFFF);
        tick(); check_ifid("e23", 1'b1, 16'hFFFF, 16'h5FFF);
        tick(); check_ifid("e24", 1'b1, 16'h0000, 16'hA000);
        check_val("e24_pc_out", pc_out, 16'h0001);

`ifdef FETCH_PERF_CNT_EN
        check_val("perf_fetched", perf_fetched, 16'd10);
        check_val("perf_stall", perf_stall, 16'd6);
`endif

        // Reset mid-request clears state at once; stale response ignored
        mem_lat = 2;
        tick();
        reset = 1'b0;
        #1;
        check_ifid("mrst", 1'b0, 16'h0000, 16'h0000);
        check_val("mrst_req", 16'(imem_req), 16'h0000);
        check_val("mrst_pc_out", pc_out, 16'h0010);
`ifdef FETCH_PERF_CNT_EN
        check_val("mrst_perf_fetched", perf_fetched, 16'd0);
        check_val("mrst_perf_stall", perf_stall, 16'd0);
`endif
        tick();
        reset   = 1'b1;
        mem_lat = 0;
        tick();
        check_val("rel_addr", imem_addr, 16'h0010);
        check_val("rel_valid", 16'(IF_ID_valid), 16'h0000);
        tick(); check_ifid("rel", 1'b1, 16'h0010, 16'hA010);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
